// File: rtl/jh_adc_pkg.sv
// Shared definitions for the ADC responder: register offsets, command fields,
// the data-register valid flag and the conversion FSM state encoding.
package jh_adc_pkg;

  localparam logic [15:0] CMD_OFS  = 16'd0;
  localparam logic [15:0] DATA_OFS = 16'd4;

  localparam int START_BIT = 0;
  localparam int CH_LSB    = 1;
  localparam int CH_MSB    = 3;
  localparam int VALID_BIT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } adc_state_e;

  // A requested count of zero still means one conversion, and the count never
  // exceeds what the FIFO can hold, so a sequence can never overflow it.
  function automatic logic [6:0] clamp_count(input logic [6:0] raw, input int unsigned depth);
    if (raw == 7'd0) return 7'd1;
    if (32'(raw) > depth) return 7'(depth);
    return raw;
  endfunction

endpackage

// File: rtl/jh_adc_responder_if.sv
// Avalon-style bus between the temperature master and the ADC responder.
interface jh_adc_responder_if;

  logic [15:0] bus_addr;
  logic [3:0]  bus_byte_enable;
  logic        bus_read;
  logic        bus_write;
  logic [15:0] bus_write_data;
  logic        bus_ack;
  logic [15:0] bus_read_data;

  modport master (
    output bus_addr, bus_byte_enable, bus_read, bus_write, bus_write_data,
    input  bus_ack, bus_read_data
  );

  modport slave (
    input  bus_addr, bus_byte_enable, bus_read, bus_write, bus_write_data,
    output bus_ack, bus_read_data
  );

endinterface

// File: rtl/jh_sync_fifo.sv
// Single-clock FIFO with synchronous flush; DEPTH must be a power of two so
// the pointers wrap naturally.
module jh_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A push while full only succeeds if a pop frees a slot in the same cycle.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jh_adc_responder.sv
// Bus responder for the ADC controller: command/data registers, conversion
// sequencing toward the front-end, and a sample FIFO read through the data register.
module jh_adc_responder
  import jh_adc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          SAMPLE_W   = 12
) (
  input  logic                clock,
  input  logic                reset_n,
  jh_adc_responder_if.slave   bus,
  output logic                conv_req,
  output logic [2:0]          conv_ch,
  input  logic                conv_valid,
  input  logic [SAMPLE_W-1:0] conv_data,
  output logic                busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  adc_state_e          state;
  logic                start_q;
  logic [6:0]          count_reg;
  logic [6:0]          sample_cnt;
  logic [15:0]         read_next;

  logic                req_any;
  logic                hit_cmd;
  logic                hit_data;
  logic                wr_en;
  logic                rd_en;
  logic                cmd_wr;
  logic                data_wr;
  logic                cmd_rd;
  logic                data_rd;
  logic                launch;
  logic                sample_take;

  logic                fifo_push;
  logic                fifo_pop;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                fifo_avail;

  // Every request is acknowledged, mapped or not; the ack cycle itself never
  // accepts, which keeps a held request from being counted twice.
  assign req_any  = (bus.bus_read || bus.bus_write) && !bus.bus_ack;
  assign hit_cmd  = (bus.bus_addr == 16'(BASE_ADDR + CMD_OFS));
  assign hit_data = (bus.bus_addr == 16'(BASE_ADDR + DATA_OFS));
  assign wr_en    = req_any && bus.bus_write && bus.bus_byte_enable[0];
  assign rd_en    = req_any && bus.bus_read && !bus.bus_write;
  assign cmd_wr   = wr_en && hit_cmd;
  assign data_wr  = wr_en && hit_data;
  assign cmd_rd   = rd_en && hit_cmd;
  assign data_rd  = rd_en && hit_data;

  assign launch      = cmd_wr && bus.bus_write_data[START_BIT] && !start_q && (state != CONVERT);
  // The request cycle is not part of the wait window, so a result strobe is
  // only taken once the request has actually gone out.
  assign sample_take = (state == CONVERT) && !conv_req && conv_valid;
  assign fifo_push   = sample_take && !fifo_full;
  assign fifo_pop    = data_rd && !fifo_empty;
  assign fifo_avail  = (fifo_count != '0);
  assign busy        = (state == CONVERT);

  jh_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (launch),
    .push      (fifo_push),
    .push_data (conv_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    read_next = '0;
    if (data_rd && fifo_avail) begin
      read_next[VALID_BIT]      = 1'b1;
      read_next[SAMPLE_W-1:0]   = fifo_head;
    end else if (cmd_rd) begin
      read_next[0] = (state == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.bus_ack       <= 1'b0;
      bus.bus_read_data <= '0;
      start_q           <= 1'b0;
      count_reg         <= 7'd1;
    end else begin
      bus.bus_ack       <= req_any;
      bus.bus_read_data <= read_next;
      if (cmd_wr)
        start_q <= bus.bus_write_data[START_BIT];
      if (data_wr && (state != CONVERT))
        count_reg <= clamp_count(bus.bus_write_data[6:0], FIFO_DEPTH);
    end
  end

  // Conversion sequencer: one request per sample, next request issued the
  // cycle after a result arrives until the programmed count is reached.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      conv_req   <= 1'b0;
      conv_ch    <= 3'd0;
      sample_cnt <= 7'd0;
    end else begin
      conv_req <= 1'b0;
      if (cmd_wr && (state != CONVERT))
        conv_ch <= bus.bus_write_data[CH_MSB:CH_LSB];
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state      <= CONVERT;
            conv_req   <= 1'b1;
            sample_cnt <= 7'd0;
          end
        end
        CONVERT: begin
          if (sample_take) begin
            sample_cnt <= sample_cnt + 7'd1;
            if (sample_cnt + 7'd1 == count_reg) state <= DONE;
            else                                conv_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jh_adc_responder.sv
// Directed plus randomized bench for jh_adc_responder with a behavioural
// front-end model and a queue holding the samples the FIFO should contain.
module tb_jh_adc_responder;

  localparam int DEPTH = 8;
  localparam logic [15:0] CMD  = 16'h0000;
  localparam logic [15:0] DATA = 16'h0004;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        conv_req;
  logic [2:0]  conv_ch;
  logic        conv_valid;
  logic [11:0] conv_data;
  logic        busy;

  always #10 clock = ~clock;

  jh_adc_responder_if bus_if();

  jh_adc_responder #(
    .BASE_ADDR  (16'h0000),
    .FIFO_DEPTH (DEPTH),
    .SAMPLE_W   (12)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .conv_req   (conv_req),
    .conv_ch    (conv_ch),
    .conv_valid (conv_valid),
    .conv_data  (conv_data),
    .busy       (busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          req_count = 0;
  int          ch_errs   = 0;
  int          fe_latency = 3;
  bit          fe_seq   = 1'b0;
  bit          fe_store = 1'b1;
  logic [11:0] fe_next  = 12'h000;
  logic [2:0]  fe_exp_ch = 3'd0;
  logic [11:0] model [$];
  int          fe_delay = 0;
  logic [11:0] fe_pend  = 12'h000;
  int          req_base = 0;
  int          ch_base  = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Front-end model: answers each request with one sample after fe_latency cycles.
  initial begin
    conv_valid = 1'b0;
    conv_data  = 12'h000;
    forever begin
      @(negedge clock);
      conv_valid = 1'b0;
      if (fe_delay > 0) begin
        fe_delay--;
        if (fe_delay == 0) begin
          conv_valid = 1'b1;
          conv_data  = fe_pend;
          if (fe_store) model.push_back(fe_pend);
        end
      end
      if (conv_req) begin
        req_count++;
        if (conv_ch !== fe_exp_ch) ch_errs++;
        fe_pend = fe_seq ? fe_next : 12'($urandom);
        if (fe_seq) fe_next = fe_next + 12'd1;
        fe_delay = fe_latency;
      end
    end
  end

  task automatic bus_xfer(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata);
    int lat;
    lat = 0;
    @(negedge clock);
    bus_if.bus_addr        = addr;
    bus_if.bus_write_data  = wdata;
    bus_if.bus_byte_enable = 4'hF;
    bus_if.bus_write       = wr;
    bus_if.bus_read        = !wr;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus_if.bus_ack && lat < 5);
    check_output("ack_latency", 32'(lat), 32'd1);
    rdata = bus_if.bus_read_data;
    bus_if.bus_write = 1'b0;
    bus_if.bus_read  = 1'b0;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [15:0] wdata);
    logic [15:0] unused_rd;
    bus_xfer(1'b1, addr, wdata, unused_rd);
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] rd;
    bus_xfer(1'b0, addr, 16'h0000, rd);
    check_output(tag, 32'(rd), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_output("idle_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!conv_req && n < 60);
    check_output("req_timeout", 32'(n < 60), 32'd1);
  endtask

  function automatic int expected_conversions(input int raw);
    if (raw < 1) return 1;
    if (raw > DEPTH) return DEPTH;
    return raw;
  endfunction

  task automatic start_seq(input logic [2:0] ch);
    wr_reg(CMD, {12'h000, ch, 1'b0});
    fe_exp_ch = ch;
    model.delete();
    req_base = req_count;
    ch_base  = ch_errs;
    wr_reg(CMD, {12'h000, ch, 1'b1});
    check_output("req_after_start", 32'(conv_req), 32'd1);
  endtask

  task automatic drain(input int n);
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = (model.size() > 0) ? (16'h8000 | 16'(model.pop_front())) : 16'h0000;
      rd_check("fifo_read", DATA, exp);
    end
    rd_check("fifo_empty_read", DATA, 16'h0000);
  endtask

  task automatic finish_seq(input int exp_n);
    wait_idle();
    check_output("conversion_count", 32'(req_count - req_base), 32'(exp_n));
    check_output("conv_ch_errors", 32'(ch_errs - ch_base), 32'd0);
    rd_check("done_flag", CMD, 16'h0001);
    check_output("model_depth", 32'(model.size()), 32'(exp_n));
    drain(exp_n);
  endtask

  initial begin
    int acks;
    int raw;
    logic [2:0] ch;
    logic [15:0] rd;

    bus_if.bus_addr        = 16'h0000;
    bus_if.bus_byte_enable = 4'h0;
    bus_if.bus_read        = 1'b0;
    bus_if.bus_write       = 1'b0;
    bus_if.bus_write_data  = 16'h0000;

    repeat (2) @(negedge clock);
    check_output("rst_ack", 32'(bus_if.bus_ack), 32'd0);
    check_output("rst_rdata", 32'(bus_if.bus_read_data), 32'd0);
    check_output("rst_conv_req", 32'(conv_req), 32'd0);
    check_output("rst_conv_ch", 32'(conv_ch), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    rd_check("idle_cmd_read", CMD, 16'h0000);
    rd_check("idle_data_read", DATA, 16'h0000);
    rd_check("unmapped_read", 16'h0008, 16'h0000);

    $display("[TB] directed sequence, channel 2, four samples");
    fe_seq = 1'b1;
    fe_next = 12'h100;
    fe_latency = 3;
    fe_exp_ch = 3'd2;
    req_base = req_count;
    ch_base = ch_errs;
    wr_reg(DATA, 16'd4);
    wr_reg(CMD, 16'h0005);
    wr_reg(CMD, 16'h0004);
    wr_reg(CMD, 16'h0005);
    wait_idle();
    check_output("dir_conversions", 32'(req_count - req_base), 32'd4);
    check_output("dir_conv_ch", 32'(ch_errs - ch_base), 32'd0);
    rd_check("dir_done", CMD, 16'h0001);
    rd_check("dir_s0", DATA, 16'h8100);
    rd_check("dir_s1", DATA, 16'h8101);
    rd_check("dir_s2", DATA, 16'h8102);
    rd_check("dir_s3", DATA, 16'h8103);
    rd_check("dir_s4_empty", DATA, 16'h0000);
    fe_seq = 1'b0;
    model.delete();

    $display("[TB] held write across several acks");
    wr_reg(DATA, 16'd1);
    wr_reg(CMD, 16'h0000);
    fe_exp_ch = 3'd0;
    model.delete();
    req_base = req_count;
    ch_base = ch_errs;
    @(negedge clock);
    bus_if.bus_addr        = CMD;
    bus_if.bus_write_data  = 16'h0001;
    bus_if.bus_byte_enable = 4'hF;
    bus_if.bus_write       = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus_if.bus_ack) acks++;
    end
    bus_if.bus_write = 1'b0;
    check_output("held_write_acks", 32'(acks), 32'd3);
    finish_seq(1);

    $display("[TB] count clamping");
    ch = 3'($urandom_range(0, 7));
    fe_latency = 2;
    wr_reg(DATA, 16'd0);
    start_seq(ch);
    finish_seq(1);
    ch = 3'($urandom_range(0, 7));
    wr_reg(DATA, 16'd40);
    start_seq(ch);
    finish_seq(DEPTH);

    $display("[TB] writes while busy are ignored");
    ch = 3'($urandom_range(0, 7));
    fe_latency = $urandom_range(3, 5);
    wr_reg(DATA, 16'd40);
    start_seq(ch);
    wr_reg(DATA, 16'd2);
    wr_reg(CMD, 16'h0000);
    wr_reg(CMD, 16'h000F);
    finish_seq(DEPTH);
    start_seq(ch);
    finish_seq(DEPTH);

    $display("[TB] randomized sequences");
    for (int i = 0; i < 4; i++) begin
      raw = $urandom_range(0, 20);
      ch = 3'($urandom_range(0, 7));
      fe_latency = $urandom_range(1, 5);
      wr_reg(DATA, 16'(raw));
      start_seq(ch);
      finish_seq(expected_conversions(raw));
    end

    $display("[TB] pop and push in the same cycle");
    fe_latency = 3;
    ch = 3'($urandom_range(0, 7));
    wr_reg(DATA, 16'd3);
    start_seq(ch);
    wait_req();
    repeat (2) @(negedge clock);
    bus_xfer(1'b0, DATA, 16'h0000, rd);
    check_output("same_cycle_pop", 32'(rd), 32'(16'h8000 | 16'(model.pop_front())));
    wait_idle();
    check_output("same_cycle_conversions", 32'(req_count - req_base), 32'd3);
    check_output("same_cycle_model", 32'(model.size()), 32'd2);
    drain(2);

    $display("[TB] reset mid-sequence");
    ch = 3'($urandom_range(0, 7));
    wr_reg(DATA, 16'd4);
    start_seq(ch);
    wait_req();
    @(negedge clock);
    fe_store = 1'b0;
    reset_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_conv_req", 32'(conv_req), 32'd0);
    check_output("abort_ack", 32'(bus_if.bus_ack), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    model.delete();
    fe_store = 1'b1;
    check_output("abort_idle", 32'(busy), 32'd0);
    rd_check("abort_fifo_empty", DATA, 16'h0000);
    rd_check("abort_done_clear", CMD, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
